// File: rtl/fir_sym_mc.sv
// Multi-channel symmetric FIR filter built around one shared pre-add/multiply/accumulate unit,
// with runtime-loadable coefficients, valid/ready on both sides and a rounded, saturated result.
module fir_sym_mc #(
   parameter int WL     = 14,
   parameter int CW     = 14,
   parameter int TAPS   = 37,
   parameter int NCH    = 2,
   parameter int OUT_WL = 20,
   parameter int SHIFT  = 13,
   localparam int F     = (TAPS + 1) / 2,
   localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1,
   localparam int AW    = (F > 1) ? $clog2(F) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [CHW-1:0]           in_ch,
   input  logic signed [WL-1:0]     in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [CHW-1:0]           out_ch,
   output logic signed [OUT_WL-1:0] out_data,
   output logic                     out_sat,
   input  logic                     coef_we,
   input  logic [AW-1:0]            coef_addr,
   input  logic signed [CW-1:0]     coef_wdata
);

   localparam int LW   = (TAPS > 1) ? $clog2(TAPS) : 1;
   localparam int ACCW = WL + CW + 1 + $clog2(F);
   localparam int PW   = WL + CW + 1;
   localparam int EW   = (ACCW + 1 > OUT_WL) ? ACCW + 1 : OUT_WL;
   localparam int SH1  = (SHIFT > 0) ? SHIFT - 1 : 0;

   localparam logic [AW-1:0]         K_LAST = AW'(F - 1);
   localparam logic [AW:0]           F_L    = (AW + 1)'(F);
   localparam logic [CHW:0]          NCH_L  = (CHW + 1)'(NCH);
   localparam logic signed [EW-1:0]  MAXV   = {{(EW - OUT_WL + 1){1'b0}}, {(OUT_WL - 1){1'b1}}};
   localparam logic signed [EW-1:0]  MINV   = ~MAXV;
   localparam logic signed [EW-1:0]  RND    = (SHIFT > 0) ? (EW'(1) <<< SH1) : '0;

   typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

   state_t                 state;
   logic signed [WL-1:0]   line [NCH][TAPS];
   logic signed [CW-1:0]   coef [F];
   logic [CHW-1:0]         ch_q;
   logic [AW-1:0]          k;
   logic signed [ACCW-1:0] acc;

   logic [LW-1:0]          lo_idx, hi_idx;
   logic signed [WL-1:0]   x_lo, x_hi;
   logic signed [WL:0]     pre;
   logic signed [PW-1:0]   term;
   logic signed [EW-1:0]   rnd_sum, shifted;

   assign in_ready = (state == IDLE);

   // Symmetric pair k and TAPS-1-k share coefficient k; the centre tap is taken alone.
   always_comb begin
      lo_idx  = LW'(k);
      hi_idx  = LW'(TAPS - 1) - LW'(k);
      x_lo    = line[ch_q][lo_idx];
      x_hi    = line[ch_q][hi_idx];
      pre     = (k == K_LAST) ? (WL + 1)'(x_lo) : (WL + 1)'(x_lo) + (WL + 1)'(x_hi);
      term    = PW'(pre) * PW'(coef[k]);
      rnd_sum = EW'(acc) + RND;
      shifted = rnd_sum >>> SHIFT;
   end

   // NOTE: all state in this block uses non-blocking assignments so every register
   // samples its inputs from the same pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ch_q      <= '0;
         k         <= '0;
         acc       <= '0;
         out_valid <= 1'b0;
         out_ch    <= '0;
         out_data  <= '0;
         out_sat   <= 1'b0;
         // NOTE: delay lines and coefficients are visible filter state that must read as
         // zero after reset, so these arrays are cleared explicitly rather than left undefined.
         for (int ci = 0; ci < NCH; ci++)
            for (int ti = 0; ti < TAPS; ti++)
               line[ci][ti] <= '0;
         for (int fi = 0; fi < F; fi++)
            coef[fi] <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (coef_we && ({1'b0, coef_addr} < F_L))
                  coef[coef_addr] <= coef_wdata;
               if (in_valid) begin
                  // Samples tagged with a channel that does not exist are swallowed.
                  if ({1'b0, in_ch} < NCH_L) begin
                     for (int ti = TAPS - 1; ti > 0; ti--)
                        line[in_ch][ti] <= line[in_ch][ti - 1];
                     line[in_ch][0] <= in_data;
                     ch_q  <= in_ch;
                     k     <= '0;
                     acc   <= '0;
                     state <= MAC;
                  end
               end
            end
            MAC: begin
               acc <= acc + ACCW'(term);
               if (k == K_LAST)
                  state <= OUT;
               else
                  k <= k + AW'(1);
            end
            OUT: begin
               // First OUT cycle formats the finished sum; afterwards hold until accepted.
               if (!out_valid) begin
                  out_valid <= 1'b1;
                  out_ch    <= ch_q;
                  if (shifted > MAXV) begin
                     out_data <= MAXV[OUT_WL-1:0];
                     out_sat  <= 1'b1;
                  end else if (shifted < MINV) begin
                     out_data <= MINV[OUT_WL-1:0];
                     out_sat  <= 1'b1;
                  end else begin
                     out_data <= shifted[OUT_WL-1:0];
                     out_sat  <= 1'b0;
                  end
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fir_sym_mc.sv
// Self-checking bench for fir_sym_mc: a direct-form convolution model drives expectations
// for two instances (full-width/no-shift, and 16-bit output with rounding shift of 2).
module tb_fir_sym_mc;

   localparam int WL   = 14;
   localparam int CW   = 14;
   localparam int TAPS = 5;
   localparam int NCH  = 2;
   localparam int F    = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 rst;
   logic [1:0]           in_valid_v, coef_we_v, out_ready_v;
   logic                 in_ch;
   logic signed [WL-1:0] in_data;
   logic [1:0]           coef_addr;
   logic signed [CW-1:0] coef_wdata;

   wire [1:0]            in_ready_v, out_valid_v, out_ch_v, out_sat_v;
   wire signed [31:0]    out_data0;
   wire signed [15:0]    out_data1;

   fir_sym_mc #(.WL(WL), .CW(CW), .TAPS(TAPS), .NCH(NCH), .OUT_WL(32), .SHIFT(0)) dut0 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]), .in_ch(in_ch), .in_data(in_data),
      .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]), .out_ch(out_ch_v[0]),
      .out_data(out_data0), .out_sat(out_sat_v[0]),
      .coef_we(coef_we_v[0]), .coef_addr(coef_addr), .coef_wdata(coef_wdata)
   );

   fir_sym_mc #(.WL(WL), .CW(CW), .TAPS(TAPS), .NCH(NCH), .OUT_WL(16), .SHIFT(2)) dut1 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]), .in_ch(in_ch), .in_data(in_data),
      .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]), .out_ch(out_ch_v[1]),
      .out_data(out_data1), .out_sat(out_sat_v[1]),
      .coef_we(coef_we_v[1]), .coef_addr(coef_addr), .coef_wdata(coef_wdata)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: per instance, per channel history and the F unique coefficients.
   longint hist [2][NCH][TAPS];
   longint cf   [2][F];

   typedef struct {
      int     ch;
      longint x;
      longint y;
   } vec_t;

   vec_t tab [12];

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic longint get_out(input int d);
      return (d == 0) ? longint'(out_data0) : longint'(out_data1);
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         for (int c = 0; c < NCH; c++)
            for (int i = 0; i < TAPS; i++)
               hist[d][c][i] = 0;
         for (int j = 0; j < F; j++)
            cf[d][j] = 0;
      end
   endtask

   task automatic model_push(input int d, input int ch, input longint x);
      for (int i = TAPS - 1; i > 0; i--)
         hist[d][ch][i] = hist[d][ch][i - 1];
      hist[d][ch][0] = x;
   endtask

   task automatic model_eval(input int d, input int ch, output longint y, output bit sat);
      longint acc, hi, lo;
      int     sh, owl, j;
      sh  = (d == 0) ? 0 : 2;
      owl = (d == 0) ? 32 : 16;
      acc = 0;
      for (int i = 0; i < TAPS; i++) begin
         j = (i < F) ? i : TAPS - 1 - i;
         acc += cf[d][j] * hist[d][ch][i];
      end
      if (sh > 0)
         acc = (acc + (longint'(1) <<< (sh - 1))) >>> sh;
      hi  = (longint'(1) <<< (owl - 1)) - 1;
      lo  = -hi - 1;
      sat = 1'b0;
      y   = acc;
      if (acc > hi) begin y = hi; sat = 1'b1; end
      if (acc < lo) begin y = lo; sat = 1'b1; end
   endtask

   task automatic do_reset();
      in_valid_v  = '0;
      coef_we_v   = '0;
      out_ready_v = 2'b11;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
   endtask

   task automatic write_coef(input int d, input int addr, input longint val);
      coef_addr     = addr[1:0];
      coef_wdata    = CW'(val);
      coef_we_v[d]  = 1'b1;
      @(posedge clk);
      #1 coef_we_v[d] = 1'b0;
      if (addr < F)
         cf[d][addr] = val;
   endtask

   // we_mode: 0 none, 1 write c[0]=11 in the accept cycle, 2 write c[0]=100 during MAC.
   task automatic run_sample(input int d, input int ch, input longint x, input bit use_model,
                             input longint tab_y, input bit tab_sat, input string name,
                             input int hold, input int we_mode);
      longint exp_y;
      bit     exp_sat;
      int     lat;
      if (we_mode == 1)
         cf[d][0] = 11;
      model_push(d, ch, x);
      if (use_model)
         model_eval(d, ch, exp_y, exp_sat);
      else begin
         exp_y   = tab_y;
         exp_sat = tab_sat;
      end
      check({name, "/in_ready"}, longint'(in_ready_v[d]), 1);
      out_ready_v[d] = (hold == 0);
      in_ch          = ch[0];
      in_data        = WL'(x);
      in_valid_v[d]  = 1'b1;
      if (we_mode == 1) begin
         coef_addr    = 2'd0;
         coef_wdata   = 14'sd11;
         coef_we_v[d] = 1'b1;
      end
      @(posedge clk);
      #1;
      in_valid_v[d] = 1'b0;
      coef_we_v[d]  = 1'b0;
      if (we_mode == 2) begin
         coef_addr    = 2'd0;
         coef_wdata   = 14'sd100;
         coef_we_v[d] = 1'b1;
      end
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         coef_we_v[d] = 1'b0;
         lat++;
      end while (!out_valid_v[d] && lat < 40);
      check({name, "/latency"}, lat, F + 1);
      check({name, "/data"}, get_out(d), exp_y);
      check({name, "/sat"}, longint'(out_sat_v[d]), longint'(exp_sat));
      check({name, "/ch"}, longint'(out_ch_v[d]), ch);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         check({name, "/hold_valid"}, longint'(out_valid_v[d]), 1);
         check({name, "/hold_data"}, get_out(d), exp_y);
         check({name, "/hold_ch"}, longint'(out_ch_v[d]), ch);
         check({name, "/hold_in_ready"}, longint'(in_ready_v[d]), 0);
      end
      out_ready_v[d] = 1'b1;
      @(posedge clk);
      #1;
      check({name, "/released"}, longint'(out_valid_v[d]), 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit seen;
      in_ch      = 1'b0;
      in_data    = '0;
      coef_addr  = '0;
      coef_wdata = '0;
      do_reset();

      for (int d = 0; d < 2; d++) begin
         check($sformatf("reset%0d/in_ready", d), longint'(in_ready_v[d]), 1);
         check($sformatf("reset%0d/out_valid", d), longint'(out_valid_v[d]), 0);
         check($sformatf("reset%0d/out_data", d), get_out(d), 0);
         check($sformatf("reset%0d/out_ch", d), longint'(out_ch_v[d]), 0);
         check($sformatf("reset%0d/out_sat", d), longint'(out_sat_v[d]), 0);
      end
      run_sample(0, 0, 1234, 1'b1, 0, 1'b0, "zero_coef", 0, 0);

      // Impulse on ch0 interleaved with constant 10 on ch1, c = {3,-2,7}.
      do_reset();
      write_coef(0, 0, 3);
      write_coef(0, 1, -2);
      write_coef(0, 2, 7);
      write_coef(0, 3, 55);
      tab[0]  = '{0, 1, 3};   tab[1]  = '{1, 10, 30};
      tab[2]  = '{0, 0, -2};  tab[3]  = '{1, 10, 10};
      tab[4]  = '{0, 0, 7};   tab[5]  = '{1, 10, 80};
      tab[6]  = '{0, 0, -2};  tab[7]  = '{1, 10, 60};
      tab[8]  = '{0, 0, 3};   tab[9]  = '{1, 10, 90};
      tab[10] = '{0, 0, 0};   tab[11] = '{1, 10, 90};
      for (int i = 0; i < 12; i++)
         run_sample(0, tab[i].ch, tab[i].x, 1'b0, tab[i].y, 1'b0,
                    $sformatf("table[%0d]", i), 0, 0);

      run_sample(0, 0, 4, 1'b1, 0, 1'b0, "backpressure", 20, 0);
      run_sample(0, 0, 2, 1'b1, 0, 1'b0, "coef_same_cycle", 0, 1);
      run_sample(0, 0, 3, 1'b1, 0, 1'b0, "coef_during_mac", 0, 2);
      run_sample(0, 1, -7, 1'b1, 0, 1'b0, "after_mac_write", 0, 0);

      for (int j = 0; j < F; j++)
         write_coef(0, j, longint'($urandom_range(16383)) - 8192);
      for (int i = 0; i < 40; i++)
         run_sample(0, int'($urandom_range(1)), longint'($urandom_range(16383)) - 8192,
                    1'b1, 0, 1'b0, $sformatf("rand0[%0d]", i), 0, 0);

      // Reset while the MAC is running: no result, and state comes back empty.
      in_ch         = 1'b0;
      in_data       = 14'sd5;
      in_valid_v[0] = 1'b1;
      @(posedge clk);
      #1 in_valid_v[0] = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      seen = 1'b0;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (out_valid_v[0])
            seen = 1'b1;
      end
      check("rst_mid_mac/no_valid", longint'(seen), 0);
      check("rst_mid_mac/in_ready", longint'(in_ready_v[0]), 1);
      run_sample(0, 1, 9, 1'b1, 0, 1'b0, "post_rst_coef_zero", 0, 0);
      write_coef(0, 0, 3);
      write_coef(0, 1, -2);
      write_coef(0, 2, 7);
      run_sample(0, 0, 0, 1'b1, 0, 1'b0, "post_rst_line_zero", 0, 0);

      // Saturation on the 16-bit instance.
      do_reset();
      write_coef(1, 2, 8191);
      run_sample(1, 0, 8191, 1'b1, 0, 1'b0, "sat_pre0", 0, 0);
      run_sample(1, 0, 8191, 1'b1, 0, 1'b0, "sat_pre1", 0, 0);
      run_sample(1, 0, 8191, 1'b0, 32767, 1'b1, "sat_pos", 0, 0);
      run_sample(1, 0, -8192, 1'b1, 0, 1'b0, "sat_pre2", 0, 0);
      run_sample(1, 0, -8192, 1'b1, 0, 1'b0, "sat_pre3", 0, 0);
      run_sample(1, 0, -8192, 1'b0, -32768, 1'b1, "sat_neg", 0, 0);

      // Round half up after a shift of 2.
      do_reset();
      write_coef(1, 2, 1);
      run_sample(1, 0, 6, 1'b1, 0, 1'b0, "rnd_pre0", 0, 0);
      run_sample(1, 0, 0, 1'b1, 0, 1'b0, "rnd_pre1", 0, 0);
      run_sample(1, 0, 0, 1'b0, 2, 1'b0, "rnd_pos", 0, 0);
      run_sample(1, 0, -6, 1'b1, 0, 1'b0, "rnd_pre2", 0, 0);
      run_sample(1, 0, 0, 1'b1, 0, 1'b0, "rnd_pre3", 0, 0);
      run_sample(1, 0, 0, 1'b0, -1, 1'b0, "rnd_neg", 0, 0);

      for (int j = 0; j < F; j++)
         write_coef(1, j, longint'($urandom_range(16383)) - 8192);
      for (int i = 0; i < 30; i++)
         run_sample(1, int'($urandom_range(1)), longint'($urandom_range(16383)) - 8192,
                    1'b1, 0, 1'b0, $sformatf("rand1[%0d]", i), 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
